// File: rtl/ga23_pkg.sv
// Shared types for the GA23 tile-ROM fetch path: SDRAM word address, row data
// and the arbiter FSM state encoding.
package ga23_pkg;

    typedef logic [21:0] sdr_addr_t;
    typedef logic [31:0] sdr_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ga23_rr_pick.sv
// Round-robin first-set-bit finder: returns the first pending port at or after
// rr, wrapping modulo NUM_PORTS.
module ga23_rr_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PW        = 2
) (
    input  logic [NUM_PORTS-1:0] pend,
    input  logic [PW-1:0]        rr,
    output logic                 valid,
    output logic [PW-1:0]        index
);

    logic [PW-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        valid = |pend;
        index = '0;
        cand  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = PW'((int'(rr) + i) % NUM_PORTS);
            if (pend[cand]) begin
                index = cand;
            end
        end
    end

endmodule

// File: rtl/ga23_sdr_arbiter.sv
// Serialises one-shot tile-row fetches from several tilemap layers onto a single
// SDRAM controller channel and returns each row to the layer that asked for it.
//
// state | meaning
// IDLE  | no transaction; grant the next pending port round-robin
// ISSUE | mem_req held with mem_addr until the controller acks
// WAIT  | accepted, waiting for mem_rdy with the row data
module ga23_sdr_arbiter
    import ga23_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int AW        = 22,
    parameter int DW        = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_PORTS-1:0]    port_req,
    input  logic [NUM_PORTS*AW-1:0] port_addr,
    output logic [DW-1:0]           port_data,
    output logic [NUM_PORTS-1:0]    port_rdy,
    output logic                    mem_req,
    output logic [AW-1:0]           mem_addr,
    input  logic                    mem_ack,
    input  logic [DW-1:0]           mem_data,
    input  logic                    mem_rdy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] stale;
    logic [AW-1:0]        addr_q [NUM_PORTS];
    logic [PW-1:0]        grant;
    logic [PW-1:0]        rr;
    logic                 pick_valid;
    logic [PW-1:0]        pick_idx;
    logic [AW-1:0]        pick_addr;
    logic                 grant_stale;
    logic                 do_grant;
    logic                 do_done;

    ga23_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .pend  (pend),
        .rr    (rr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   if (mem_ack) state_d = mem_rdy ? IDLE : WAIT;
            WAIT:    if (mem_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An ack and rdy landing together in ISSUE complete the transaction directly.
    always_comb begin
        mem_req  = 1'b0;
        do_grant = 1'b0;
        do_done  = 1'b0;
        case (state_q)
            IDLE:  do_grant = pick_valid;
            ISSUE: begin
                mem_req = 1'b1;
                do_done = mem_ack && mem_rdy;
            end
            WAIT:  do_done = mem_rdy;
            default: ;
        endcase
    end

    always_comb begin
        pick_addr   = '0;
        grant_stale = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick_idx == PW'(p)) pick_addr = addr_q[p];
            if (grant == PW'(p)) grant_stale = stale[p];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= '0;
            stale     <= '0;
            grant     <= '0;
            rr        <= '0;
            mem_addr  <= '0;
            port_data <= '0;
            port_rdy  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                addr_q[p] <= '0;
            end
        end else begin
            port_rdy <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                // A fresh request keeps the port pending even in its own grant cycle.
                if (port_req[p]) begin
                    addr_q[p] <= port_addr[p*AW +: AW];
                    pend[p]   <= 1'b1;
                end else if (do_grant && pick_idx == PW'(p)) begin
                    pend[p] <= 1'b0;
                end
                if (do_done && grant == PW'(p)) begin
                    stale[p] <= 1'b0;
                    if (!stale[p]) port_rdy[p] <= 1'b1;
                end else if (port_req[p] && state_q != IDLE && grant == PW'(p)) begin
                    stale[p] <= 1'b1;
                end
            end
            if (do_grant) begin
                grant    <= pick_idx;
                mem_addr <= pick_addr;
            end
            if (do_done) begin
                rr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);
                if (!grant_stale) port_data <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Directed bench for ga23_sdr_arbiter: the controller side is driven by hand,
// cycle by cycle, and each observation is checked against a hand-derived value.
module tb_ga23_sdr_arbiter;
    import ga23_pkg::*;

    localparam int NP = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic             clk;
    logic             reset_n;
    logic [NP-1:0]    port_req;
    logic [NP*AW-1:0] port_addr;
    logic [DW-1:0]    port_data;
    logic [NP-1:0]    port_rdy;
    logic             mem_req;
    logic [AW-1:0]    mem_addr;
    logic             mem_ack;
    logic [DW-1:0]    mem_data;
    logic             mem_rdy;

    int checks = 0;
    int errors = 0;

    ga23_sdr_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .port_req  (port_req),
        .port_addr (port_addr),
        .port_data (port_data),
        .port_rdy  (port_rdy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .mem_rdy   (mem_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int p, input sdr_addr_t a);
        port_req = '0;
        port_req[p] = 1'b1;
        port_addr[p*AW +: AW] = a;
        tick();
        port_req = '0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd1);
    endtask

    task automatic serve(input string tag, input sdr_addr_t exp_addr, input sdr_data_t d,
                         input logic [NP-1:0] exp_rdy, input sdr_data_t exp_pdata);
        wait_req(tag);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        mem_rdy  = 1'b1;
        mem_data = d;
        tick();
        mem_rdy = 1'b0;
        chk({tag, "_rdy"}, 64'(port_rdy), 64'(exp_rdy));
        chk({tag, "_data"}, 64'(port_data), 64'(exp_pdata));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        reset_n   = 1'b0;
        port_req  = '0;
        port_addr = '0;
        mem_ack   = 1'b0;
        mem_data  = '0;
        mem_rdy   = 1'b0;
        do_reset();

        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_port_rdy", 64'(port_rdy), 64'd0);
        chk("rst_port_data", 64'(port_data), 64'd0);

        // single request, latency checked cycle by cycle
        port_req = 3'b010;
        port_addr[1*AW +: AW] = 22'h0ABCD0;
        tick();
        port_req = '0;
        chk("t1_cyc1_req", 64'(mem_req), 64'd0);
        tick();
        chk("t1_cyc2_req", 64'(mem_req), 64'd1);
        chk("t1_addr", 64'(mem_addr), 64'h0ABCD0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_req_drop", 64'(mem_req), 64'd0);
        tick();
        tick();
        tick();
        chk("t1_no_early_rdy", 64'(port_rdy), 64'd0);
        mem_rdy  = 1'b1;
        mem_data = 32'hDEADBEEF;
        tick();
        mem_rdy = 1'b0;
        chk("t1_rdy", 64'(port_rdy), 64'b010);
        chk("t1_data", 64'(port_data), 64'hDEADBEEF);
        tick();
        chk("t1_rdy_once", 64'(port_rdy), 64'd0);
        chk("t1_data_hold", 64'(port_data), 64'hDEADBEEF);

        // simultaneous requests from rr = 0
        do_reset();
        port_req = 3'b111;
        port_addr[0*AW +: AW] = 22'h100;
        port_addr[1*AW +: AW] = 22'h200;
        port_addr[2*AW +: AW] = 22'h300;
        tick();
        port_req = '0;
        serve("t2_a", 22'h100, 32'h11111111, 3'b001, 32'h11111111);
        serve("t2_b", 22'h200, 32'h22222222, 3'b010, 32'h22222222);
        serve("t2_c", 22'h300, 32'h33333333, 3'b100, 32'h33333333);

        // fairness: port 0 keeps re-requesting, port 2 must get the second grant
        port_req = 3'b101;
        port_addr[0*AW +: AW] = 22'h011;
        port_addr[2*AW +: AW] = 22'h022;
        tick();
        port_req = '0;
        serve("t3_g0", 22'h011, 32'hA0000001, 3'b001, 32'hA0000001);
        pulse(0, 22'h012);
        serve("t3_g2", 22'h022, 32'hA0000002, 3'b100, 32'hA0000002);
        serve("t3_g0b", 22'h012, 32'hA0000003, 3'b001, 32'hA0000003);

        // overwrite while pending, with port 0 occupying the channel
        pulse(0, 22'h050);
        wait_req("t4_busy");
        pulse(2, 22'h040);
        pulse(2, 22'h080);
        chk("t4_hold_req", 64'(mem_req), 64'd1);
        chk("t4_hold_addr", 64'(mem_addr), 64'h050);
        serve("t4_p0", 22'h050, 32'hB0000050, 3'b001, 32'hB0000050);
        serve("t4_p2", 22'h080, 32'hB0000080, 3'b100, 32'hB0000080);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_req === 1'b1) cnt++;
        end
        chk("t4_single_txn", 64'(cnt), 64'd0);

        // stale in-flight result is dropped
        pulse(0, 22'h010);
        wait_req("t5_first");
        chk("t5_first_addr", 64'(mem_addr), 64'h010);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        pulse(0, 22'h020);
        mem_rdy  = 1'b1;
        mem_data = 32'hBAD00010;
        tick();
        mem_rdy = 1'b0;
        chk("t5_stale_rdy", 64'(port_rdy), 64'd0);
        chk("t5_stale_data", 64'(port_data), 64'hB0000080);
        serve("t5_second", 22'h020, 32'h600D0020, 3'b001, 32'h600D0020);
        tick();
        chk("t5_rdy_once", 64'(port_rdy), 64'd0);

        // reset during ISSUE, then a late mem_rdy
        pulse(1, 22'h0F0F0);
        wait_req("t6_issue");
        reset_n = 1'b0;
        #1;
        chk("t6_async_req", 64'(mem_req), 64'd0);
        chk("t6_async_rdy", 64'(port_rdy), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        mem_rdy  = 1'b1;
        mem_data = 32'hFEEDFACE;
        tick();
        mem_rdy = 1'b0;
        chk("t6_late_rdy", 64'(port_rdy), 64'd0);
        chk("t6_late_data", 64'(port_data), 64'd0);
        tick();
        chk("t6_idle_req", 64'(mem_req), 64'd0);

        // normal service after reset: stray rdy in ISSUE ignored, then ack+rdy together
        pulse(1, 22'h0ABAB);
        wait_req("t6_new");
        chk("t6_new_addr", 64'(mem_addr), 64'h0ABAB);
        mem_rdy  = 1'b1;
        mem_data = 32'h12345678;
        tick();
        mem_rdy = 1'b0;
        chk("t6_rdy_no_ack_req", 64'(mem_req), 64'd1);
        chk("t6_rdy_no_ack_rdy", 64'(port_rdy), 64'd0);
        mem_ack  = 1'b1;
        mem_rdy  = 1'b1;
        mem_data = 32'hCAFE0001;
        tick();
        mem_ack = 1'b0;
        mem_rdy = 1'b0;
        chk("t6_both_rdy", 64'(port_rdy), 64'b010);
        chk("t6_both_data", 64'(port_data), 64'hCAFE0001);
        tick();
        chk("t6_end_req", 64'(mem_req), 64'd0);
        chk("t6_end_rdy", 64'(port_rdy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
